// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types, event encoding and the action-priority resolver.
// Pure declarations; no latency, no backpressure.
package stopwatch_pkg;

    localparam int unsigned SW_CLKS_PER_TICK = 100_000_000;

    // Event vector bit index doubles as priority: the higher bit wins.
    localparam int EVT_W     = 4;
    localparam int EVT_LAP   = 0;
    localparam int EVT_START = 1;
    localparam int EVT_STOP  = 2;
    localparam int EVT_RESET = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_t;

    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_LAP   = 3'd1,
        ACT_START = 3'd2,
        ACT_STOP  = 3'd3,
        ACT_RESET = 3'd4
    } sw_act_t;

    // Events that mean nothing in the current state are masked first, so a
    // dropped higher-priority event cannot shadow a lower one that does apply.
    function automatic sw_act_t sw_pick_action(input sw_state_t st,
                                               input logic [EVT_W-1:0] evt);
        logic [EVT_W-1:0] w_app;
        sw_act_t          w_act;
        w_app = evt;
        if (st != RUNNING) begin
            w_app[EVT_STOP] = 1'b0;
            w_app[EVT_LAP]  = 1'b0;
        end else begin
            w_app[EVT_START] = 1'b0;
        end
        w_act = ACT_NONE;
        if (w_app[EVT_RESET])      w_act = ACT_RESET;
        else if (w_app[EVT_STOP])  w_act = ACT_STOP;
        else if (w_app[EVT_START]) w_act = ACT_START;
        else if (w_app[EVT_LAP])   w_act = ACT_LAP;
        return w_act;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detect for one raw button.
// Event valid 2 cycles after first sample; no backpressure (event is a pulse).
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic evt_out
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign evt_out = r_sync2 & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM, prescaler timebase and lap hold.
// State/clear/lap update 2 edges after a button is first sampled; no backpressure.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = SW_CLKS_PER_TICK,
    parameter int unsigned PW            = $clog2(CLKS_PER_TICK)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_start,
    input  logic btn_stop,
    input  logic btn_reset,
    input  logic btn_lap,
    output logic tick_en,
    output logic clear,
    output logic running,
    output logic paused,
    output logic lap_hold
);

    localparam logic [PW-1:0] TC = PW'(CLKS_PER_TICK - 1);

    logic [EVT_W-1:0] w_evt;
    sw_act_t          w_act;
    sw_state_t        r_state;
    sw_state_t        w_state_nxt;
    logic [PW-1:0]    r_presc;
    logic             r_tick_en;
    logic             r_clear;
    logic             r_lap_hold;

    btn_sync_edge u_sync_start (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_in  (btn_start),
        .evt_out (w_evt[EVT_START])
    );

    btn_sync_edge u_sync_stop (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_in  (btn_stop),
        .evt_out (w_evt[EVT_STOP])
    );

    btn_sync_edge u_sync_reset (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_in  (btn_reset),
        .evt_out (w_evt[EVT_RESET])
    );

    btn_sync_edge u_sync_lap (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_in  (btn_lap),
        .evt_out (w_evt[EVT_LAP])
    );

    assign w_act = sw_pick_action(r_state, w_evt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (w_act)
            ACT_RESET: w_state_nxt = IDLE;
            ACT_STOP:  w_state_nxt = PAUSED;
            ACT_START: w_state_nxt = RUNNING;
            default:   w_state_nxt = r_state;
        endcase
    end

    always_comb begin
        running = (r_state == RUNNING);
        paused  = (r_state == PAUSED);
    end

    // A stop on terminal count leaves the prescaler at TC, so resume ticks next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_act == ACT_RESET || r_state == IDLE) begin
            r_presc <= '0;
        end else if (r_state == RUNNING && w_act != ACT_STOP) begin
            r_presc <= (r_presc == TC) ? '0 : r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_en  <= 1'b0;
            r_clear    <= 1'b0;
            r_lap_hold <= 1'b0;
        end else begin
            r_tick_en <= (r_state == RUNNING) && (r_presc == TC) &&
                         (w_act != ACT_RESET) && (w_act != ACT_STOP);
            r_clear   <= (w_act == ACT_RESET);
            if (w_act == ACT_RESET)    r_lap_hold <= 1'b0;
            else if (w_act == ACT_LAP) r_lap_hold <= ~r_lap_hold;
        end
    end

    assign tick_en  = r_tick_en;
    assign clear    = r_clear;
    assign lap_hold = r_lap_hold;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at CLKS_PER_TICK = 4.
// Outputs are packed {running, paused, lap_hold, clear, tick_en} and checked 1 time unit after each edge.
module tb_stopwatch_ctrl;

    logic clk;
    logic rst_n;
    logic btn_start;
    logic btn_stop;
    logic btn_reset;
    logic btn_lap;
    logic tick_en;
    logic clear;
    logic running;
    logic paused;
    logic lap_hold;

    int n_vec;
    int n_err;

    stopwatch_ctrl #(
        .CLKS_PER_TICK (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .btn_reset (btn_reset),
        .btn_lap   (btn_lap),
        .tick_en   (tick_en),
        .clear     (clear),
        .running   (running),
        .paused    (paused),
        .lap_hold  (lap_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // exp order: running, paused, lap_hold, clear, tick_en
    task automatic expect_o(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {running, paused, lap_hold, clear, tick_en};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_reset = 1'b0;
        btn_lap   = 1'b0;

        repeat (2) cyc();
        expect_o("reset_state", 5'b00000);
        rst_n = 1'b1;
        cyc();
        expect_o("post_release", 5'b00000);

        // Start from IDLE, button held for 10 cycles.
        btn_start = 1'b1;
        cyc();
        cyc();
        expect_o("start_latency", 5'b00000);
        cyc();
        expect_o("start_running", 5'b10000);
        for (int i = 1; i <= 12; i++) begin
            if (i == 7) btn_start = 1'b0;
            cyc();
            expect_o($sformatf("run_tick_%0d", i), (i % 4 == 0) ? 5'b10001 : 5'b10000);
        end

        // Stop acts while prescaler = 2.
        btn_stop = 1'b1;
        cyc();
        expect_o("stop_lat_a", 5'b10000);
        cyc();
        expect_o("stop_lat_b", 5'b10000);
        cyc();
        expect_o("paused_enter", 5'b01000);
        btn_stop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            expect_o($sformatf("paused_hold_%0d", i), 5'b01000);
        end

        // Resume: held prescaler 2 -> tick 2 cycles after running rises.
        btn_start = 1'b1;
        cyc();
        cyc();
        expect_o("resume_latency", 5'b01000);
        cyc();
        expect_o("resume_running", 5'b10000);
        btn_start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            expect_o($sformatf("resume_tick_%0d", i), (i == 2 || i == 6) ? 5'b10001 : 5'b10000);
        end

        // Reset and start together while RUNNING.
        btn_reset = 1'b1;
        btn_start = 1'b1;
        cyc();
        expect_o("simul_lat_a", 5'b10000);
        cyc();
        expect_o("simul_lat_b", 5'b10000);
        cyc();
        expect_o("simul_clear", 5'b00010);
        cyc();
        expect_o("simul_clear_end", 5'b00000);
        btn_reset = 1'b0;
        btn_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            expect_o($sformatf("simul_idle_%0d", i), 5'b00000);
        end

        // Stop coinciding with terminal count.
        btn_start = 1'b1;
        cyc();
        cyc();
        expect_o("tc_start_lat", 5'b00000);
        cyc();
        expect_o("tc_running", 5'b10000);
        btn_start = 1'b0;
        cyc();
        expect_o("tc_p1", 5'b10000);
        btn_stop = 1'b1;
        cyc();
        expect_o("tc_p2", 5'b10000);
        cyc();
        expect_o("tc_p3", 5'b10000);
        cyc();
        expect_o("tc_stop_no_tick", 5'b01000);
        btn_stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            expect_o($sformatf("tc_paused_%0d", i), 5'b01000);
        end
        btn_start = 1'b1;
        cyc();
        cyc();
        expect_o("tc_resume_lat", 5'b01000);
        cyc();
        expect_o("tc_resume_running", 5'b10000);
        btn_start = 1'b0;
        cyc();
        expect_o("tc_resume_tick", 5'b10001);

        // Lap toggling while counting.
        btn_lap = 1'b1;
        cyc();
        expect_o("lap1_lat_a", 5'b10000);
        cyc();
        expect_o("lap1_lat_b", 5'b10000);
        cyc();
        expect_o("lap1_set", 5'b10100);
        btn_lap = 1'b0;
        cyc();
        expect_o("lap1_tick_kept", 5'b10101);
        cyc();
        cyc();
        expect_o("lap1_hold", 5'b10100);
        btn_lap = 1'b1;
        cyc();
        expect_o("lap2_lat_a", 5'b10100);
        cyc();
        expect_o("lap2_lat_b_tick", 5'b10101);
        cyc();
        expect_o("lap2_cleared", 5'b10000);
        btn_lap = 1'b0;
        cyc();
        cyc();
        expect_o("lap3_pre", 5'b10000);
        btn_lap = 1'b1;
        cyc();
        cyc();
        cyc();
        expect_o("lap3_set", 5'b10100);
        btn_lap = 1'b0;

        // Pause with lap held, then a lap while PAUSED is ignored.
        btn_stop = 1'b1;
        cyc();
        expect_o("lap_stop_lat_a", 5'b10100);
        cyc();
        expect_o("lap_stop_tick", 5'b10101);
        cyc();
        expect_o("lap_paused", 5'b01100);
        btn_stop = 1'b0;
        btn_lap  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            expect_o($sformatf("lap_in_pause_%0d", i), 5'b01100);
        end
        btn_lap = 1'b0;

        // Reset from PAUSED clears lap_hold, then a reset while IDLE still pulses clear.
        btn_reset = 1'b1;
        cyc();
        expect_o("rst_pause_lat_a", 5'b01100);
        cyc();
        expect_o("rst_pause_lat_b", 5'b01100);
        cyc();
        expect_o("rst_pause_clear", 5'b00010);
        btn_reset = 1'b0;
        cyc();
        expect_o("rst_pause_idle", 5'b00000);
        cyc();
        btn_reset = 1'b1;
        cyc();
        cyc();
        expect_o("rst_idle_lat", 5'b00000);
        cyc();
        expect_o("rst_idle_clear", 5'b00010);
        cyc();
        expect_o("rst_idle_end", 5'b00000);
        btn_reset = 1'b0;

        // Asynchronous reset mid-RUNNING with lap_hold set, one cycle before a tick.
        btn_start = 1'b1;
        cyc();
        cyc();
        expect_o("async_start_lat", 5'b00000);
        cyc();
        expect_o("async_running", 5'b10000);
        btn_start = 1'b0;
        btn_lap   = 1'b1;
        cyc();
        cyc();
        cyc();
        expect_o("async_lap_set", 5'b10100);
        btn_lap = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        expect_o("async_immediate", 5'b00000);
        cyc();
        expect_o("async_held_a", 5'b00000);
        cyc();
        expect_o("async_held_b", 5'b00000);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            expect_o($sformatf("async_after_%0d", i), 5'b00000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
